// File: rtl/conv_reencoder.sv
// Convolutional re-encoder: K-bit encoder shift register feeding NCH parity
// channels through a fully registered pairwise XOR tree, with zero-tail flush.
module conv_reencoder #(
  parameter int              K        = 89,
  parameter int              NCH      = 2,
  parameter int              TAIL     = K - 1,
  parameter logic [NCH*K-1:0] MASK_DEF = {NCH{{K{1'b1}}}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_vld,
  input  logic             i_bit,
  input  logic             i_flush,
  input  logic             i_diff_en,
  input  logic             i_cfg_ld,
  input  logic [NCH*K-1:0] i_mask,
  output logic             o_rdy,
  output logic             o_vld,
  output logic [NCH-1:0]   o_par,
  output logic             o_last
);

  // Width of tree level l (level 0 = the K AND terms) and its bit offset
  // inside the flattened per-channel tree vector.
  function automatic int lvl_w(input int l);
    int w;
    w = K;
    for (int i = 0; i < l; i++) w = (w + 1) / 2;
    return w;
  endfunction

  function automatic int lvl_off(input int l);
    int o;
    o = 0;
    for (int i = 0; i < l; i++) o += lvl_w(i);
    return o;
  endfunction

  localparam int LVL = $clog2(K);
  localparam int LAT = 1 + LVL;
  localparam int TOT = lvl_off(LVL + 1);
  localparam int TCW = $clog2(TAIL + 1);

  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  state_e             state_q, state_d;
  logic [TCW-1:0]     tail_q, tail_d;
  logic [K-1:0]       sr_q, sr_d, sr_new;
  logic               diff_q, diff_d, d_bit;
  logic [NCH*K-1:0]   mask_q, mask_d;
  logic               in_vld, in_last;
  logic [LAT-1:0]     vld_q, last_q;
  logic [NCH-1:0][TOT-1:0] tree_q, tree_d;

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    tail_d  = tail_q;
    sr_d    = sr_q;
    diff_d  = diff_q;
    mask_d  = mask_q;
    sr_new  = sr_q;
    d_bit   = 1'b0;
    in_vld  = 1'b0;
    in_last = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (i_vld) begin
          d_bit  = i_bit ^ (i_diff_en & diff_q);
          diff_d = d_bit;
          sr_new = {sr_q[K-2:0], d_bit};
          sr_d   = sr_new;
          in_vld = 1'b1;
        end else if (i_cfg_ld) begin
          mask_d = i_mask;
        end
        // A bit presented with the flush request is encoded before the tail.
        if (i_flush) begin
          state_d = ST_FLUSH;
          tail_d  = TCW'(TAIL);
        end
      end
      ST_FLUSH: begin
        sr_new = {sr_q[K-2:0], 1'b0};
        sr_d   = sr_new;
        in_vld = 1'b1;
        tail_d = tail_q - TCW'(1);
        if (tail_q == TCW'(1)) begin
          in_last = 1'b1;
          state_d = ST_RUN;
          sr_d    = '0;
          diff_d  = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign tree_d[c][K-1:0] = sr_new & mask_q[c*K +: K];
    for (genvar l = 1; l <= LVL; l++) begin : g_lvl
      for (genvar j = 0; j < lvl_w(l); j++) begin : g_node
        localparam int SRC = lvl_off(l - 1) + 2 * j;
        localparam int DST = lvl_off(l) + j;
        if (2 * j + 1 < lvl_w(l - 1)) begin : g_xor
          assign tree_d[c][DST] = tree_q[c][SRC] ^ tree_q[c][SRC+1];
        end else begin : g_pass
          assign tree_d[c][DST] = tree_q[c][SRC];
        end
      end
    end
    assign o_par[c] = tree_q[c][TOT-1];
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the pipeline is cleared too so o_par reads 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      tail_q  <= '0;
      sr_q    <= '0;
      diff_q  <= 1'b0;
      mask_q  <= MASK_DEF;
      vld_q   <= '0;
      last_q  <= '0;
      tree_q  <= '0;
    end else begin
      state_q <= state_d;
      tail_q  <= tail_d;
      sr_q    <= sr_d;
      diff_q  <= diff_d;
      mask_q  <= mask_d;
      vld_q   <= {vld_q[LAT-2:0], in_vld};
      last_q  <= {last_q[LAT-2:0], in_last};
      tree_q  <= tree_d;
    end
  end

  assign o_rdy  = (state_q == ST_RUN);
  assign o_vld  = vld_q[LAT-1];
  assign o_last = last_q[LAT-1];

endmodule

// File: tb/tb_conv_reencoder.sv
// Self-checking bench for conv_reencoder (K=3, NCH=2, TAIL=2): directed
// scenarios plus random traffic against a history-based parity model.
module tb_conv_reencoder;

  localparam int K    = 3;
  localparam int NCH  = 2;
  localparam int TAIL = 2;
  localparam int LAT  = 3;
  localparam logic [NCH*K-1:0] MDEF = {3'b101, 3'b111};

  logic             clk = 1'b0;
  logic             reset;
  logic             i_vld, i_bit, i_flush, i_diff_en, i_cfg_ld;
  logic [NCH*K-1:0] i_mask;
  logic             o_rdy, o_vld, o_last;
  logic [NCH-1:0]   o_par;

  conv_reencoder #(.K(K), .NCH(NCH), .TAIL(TAIL), .MASK_DEF(MDEF)) dut (
    .clk(clk), .reset(reset), .i_vld(i_vld), .i_bit(i_bit), .i_flush(i_flush),
    .i_diff_en(i_diff_en), .i_cfg_ld(i_cfg_ld), .i_mask(i_mask),
    .o_rdy(o_rdy), .o_vld(o_vld), .o_par(o_par), .o_last(o_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             due;
    logic [NCH-1:0] par;
    logic           last;
  } exp_t;

  int             total = 0;
  int             bad   = 0;
  int             cyc   = 0;
  bit             chk_en = 1'b0;
  bit             post_rst = 1'b0;
  exp_t           exp_q[$];
  logic [NCH-1:0] log_q[$];

  // Reference model: register contents as a list of bits, newest first.
  int             m_hist[$];
  logic [K-1:0]   m_mask [NCH];
  bit             m_flush;
  int             m_tail;
  int             m_diff;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH-1:0] model_par();
    logic [NCH-1:0] p;
    for (int c = 0; c < NCH; c++) begin
      int s = 0;
      for (int i = 0; i < K; i++) s += m_hist[i] * int'(m_mask[c][i]);
      p[c] = (s % 2) != 0;
    end
    return p;
  endfunction

  task automatic model_clear();
    m_hist.delete();
    for (int i = 0; i < K; i++) m_hist.push_back(0);
    m_diff = 0;
  endtask

  task automatic model_shift(input int b, input logic last);
    exp_t e;
    void'(m_hist.pop_back());
    m_hist.push_front(b);
    e.due  = cyc + LAT;
    e.par  = model_par();
    e.last = last;
    exp_q.push_back(e);
  endtask

  // One clock cycle: check outputs of this cycle, then apply this cycle's
  // inputs to the model, then advance past the active edge.
  task automatic tick();
    int d;
    @(negedge clk);
    if (chk_en) begin
      chk("rdy", o_rdy, !m_flush);
      if (post_rst) begin
        chk("rst_par", o_par, 0);
        post_rst = 1'b0;
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        chk("vld", o_vld, 1);
        chk("par", o_par, exp_q[0].par);
        chk("last", o_last, exp_q[0].last);
        log_q.push_back(o_par);
        void'(exp_q.pop_front());
      end else begin
        chk("idle_vld", o_vld, 0);
        chk("idle_last", o_last, 0);
      end
    end
    if (reset) begin
      model_clear();
      for (int c = 0; c < NCH; c++) m_mask[c] = MDEF[c*K +: K];
      m_flush  = 1'b0;
      m_tail   = 0;
      exp_q.delete();
      post_rst = 1'b1;
    end else if (!m_flush) begin
      if (i_vld) begin
        d = i_diff_en ? (int'(i_bit) ^ m_diff) : int'(i_bit);
        m_diff = d;
        model_shift(d, 1'b0);
      end else if (i_cfg_ld) begin
        for (int c = 0; c < NCH; c++) m_mask[c] = i_mask[c*K +: K];
      end
      if (i_flush) begin
        m_flush = 1'b1;
        m_tail  = TAIL;
      end
    end else begin
      model_shift(0, m_tail == 1);
      m_tail--;
      if (m_tail == 0) begin
        m_flush = 1'b0;
        model_clear();
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic b);
    i_vld = 1'b1;
    i_bit = b;
    tick();
    i_vld = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; i_vld = 1'b0; i_bit = 1'b0; i_flush = 1'b0;
    i_diff_en = 1'b0; i_cfg_ld = 1'b0; i_mask = '0;
    tick();
    tick();
    reset  = 1'b0;
    chk_en = 1'b1;

    // T1: plain encoding, back-to-back bits
    log_q.delete();
    send(1); send(0); send(1); send(1);
    idle(5);
    chk("t1_n", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("t1_0", log_q[0], 2'b11);
      chk("t1_1", log_q[1], 2'b01);
      chk("t1_2", log_q[2], 2'b00);
      chk("t1_3", log_q[3], 2'b10);
    end

    // T2: flush after T1, then a fresh bit from a cleared register
    log_q.delete();
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    idle(5);
    chk("t2_n", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t2_0", log_q[0], 2'b10);
      chk("t2_1", log_q[1], 2'b11);
    end
    log_q.delete();
    send(1);
    idle(4);
    chk("t2_after", log_q.size() == 1 ? log_q[0] : 2'bxx, 2'b11);

    // T3: differential pre-coding
    do_reset();
    log_q.delete();
    i_diff_en = 1'b1;
    send(1); send(1); send(1);
    i_diff_en = 1'b0;
    idle(4);
    chk("t3_n", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("t3_0", log_q[0], 2'b11);
      chk("t3_1", log_q[1], 2'b01);
      chk("t3_2", log_q[2], 2'b00);
    end

    // T4: load dropped when i_vld wins, then taken when i_vld is low
    do_reset();
    log_q.delete();
    i_mask = {3'b110, 3'b011};
    i_cfg_ld = 1'b1; i_vld = 1'b1; i_bit = 1'b1;
    tick();
    i_cfg_ld = 1'b0; i_vld = 1'b0;
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    idle(2);
    i_cfg_ld = 1'b1; tick(); i_cfg_ld = 1'b0;
    send(1);
    idle(4);
    chk("t4_n", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("t4_drop", log_q[0], 2'b11);
      chk("t4_load", log_q[3], 2'b01);
    end

    // T5: bit and flush together; bits during FLUSH are ignored
    do_reset();
    log_q.delete();
    i_vld = 1'b1; i_bit = 1'b1; i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    tick(); tick();
    i_vld = 1'b0;
    idle(5);
    chk("t5_n", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("t5_0", log_q[0], 2'b11);
      chk("t5_1", log_q[1], 2'b01);
      chk("t5_2", log_q[2], 2'b11);
    end

    // T6: reset in the middle of a flush restores default masks
    do_reset();
    i_mask = {3'b110, 3'b011};
    i_cfg_ld = 1'b1; tick(); i_cfg_ld = 1'b0;
    send(1);
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    tick();
    do_reset();
    log_q.delete();
    send(1);
    idle(4);
    chk("t6_n", log_q.size(), 1);
    if (log_q.size() == 1) chk("t6_0", log_q[0], 2'b11);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      i_vld     = ($urandom_range(0, 99) < 60);
      i_bit     = 1'($urandom);
      i_diff_en = 1'($urandom);
      i_flush   = ($urandom_range(0, 99) < 6);
      i_cfg_ld  = ($urandom_range(0, 99) < 10);
      i_mask    = (NCH*K)'($urandom);
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    i_vld = 1'b0; i_flush = 1'b0; i_cfg_ld = 1'b0; reset = 1'b0;
    idle(8);
    chk("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
